// File: rtl/de4_sopc_clock_0_pkg.sv
// Shared types and constants for the clock_0 clock-crossing bridge.
package de4_sopc_clock_0_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT
    } state_t;

endpackage

// File: rtl/de4_sopc_clock_0_master_fsm.sv
// Master-domain sequencer: turns request pulses into Avalon-MM strobes and
// reports each completion back to the slave domain as a level toggle.
module de4_sopc_clock_0_master_fsm
    import de4_sopc_clock_0_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  slave_read_request,
    input  logic                  slave_write_request,
    input  logic                  master_waitrequest,
    input  logic [DATA_WIDTH-1:0] master_readdata,
    output logic                  master_read,
    output logic                  master_write,
    output logic                  master_read_done,
    output logic                  master_write_done,
    output logic [DATA_WIDTH-1:0] captured_readdata
);

    state_t                state, state_nxt;
    logic                  read_pend, write_pend;
    logic                  read_pend_nxt, write_pend_nxt;
    logic                  read_nxt, write_nxt;
    logic                  read_done_nxt, write_done_nxt;
    logic [DATA_WIDTH-1:0] capture_nxt;

    always_comb begin
        state_nxt      = state;
        // Pulses fold into the pending flags in every state; a repeat merges.
        read_pend_nxt  = read_pend | slave_read_request;
        write_pend_nxt = write_pend | slave_write_request;
        read_nxt       = master_read;
        write_nxt      = master_write;
        read_done_nxt  = master_read_done;
        write_done_nxt = master_write_done;
        capture_nxt    = captured_readdata;

        case (state)
            IDLE: begin
                if (read_pend_nxt) begin
                    state_nxt     = READ_WAIT;
                    read_pend_nxt = 1'b0;
                    read_nxt      = 1'b1;
                end else if (write_pend_nxt) begin
                    state_nxt      = WRITE_WAIT;
                    write_pend_nxt = 1'b0;
                    write_nxt      = 1'b1;
                end
            end
            READ_WAIT: begin
                if (master_read && !master_waitrequest) begin
                    capture_nxt   = master_readdata;
                    read_done_nxt = ~master_read_done;
                    read_nxt      = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            WRITE_WAIT: begin
                if (master_write && !master_waitrequest) begin
                    write_done_nxt = ~master_write_done;
                    write_nxt      = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                read_nxt  = 1'b0;
                write_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            read_pend         <= 1'b0;
            write_pend        <= 1'b0;
            master_read       <= 1'b0;
            master_write      <= 1'b0;
            master_read_done  <= 1'b0;
            master_write_done <= 1'b0;
            captured_readdata <= '0;
        end else begin
            state             <= state_nxt;
            read_pend         <= read_pend_nxt;
            write_pend        <= write_pend_nxt;
            master_read       <= read_nxt;
            master_write      <= write_nxt;
            master_read_done  <= read_done_nxt;
            master_write_done <= write_done_nxt;
            captured_readdata <= capture_nxt;
        end
    end

endmodule

// File: tb/tb_de4_sopc_clock_0_master_fsm.sv
// Scoreboard bench: expected transfers are queued when requests are driven and
// retired when the DUT completes a strobe; directed checks cover strobe timing.
module tb_de4_sopc_clock_0_master_fsm;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        slave_read_request, slave_write_request;
    logic        master_waitrequest;
    logic [31:0] master_readdata;
    logic        master_read, master_write;
    logic        master_read_done, master_write_done;
    logic [31:0] captured_readdata;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        is_rd;
        logic [31:0] data;
    } xact_t;

    xact_t sb[$];

    de4_sopc_clock_0_master_fsm #(.DATA_WIDTH(32)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .slave_read_request (slave_read_request),
        .slave_write_request(slave_write_request),
        .master_waitrequest (master_waitrequest),
        .master_readdata    (master_readdata),
        .master_read        (master_read),
        .master_write       (master_write),
        .master_read_done   (master_read_done),
        .master_write_done  (master_write_done),
        .captured_readdata  (captured_readdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: expected done levels and captured data advance only when a
    // queued transfer is retired.
    initial begin
        logic [31:0] exp_cap;
        logic        exp_rd_t, exp_wr_t;
        xact_t       x;
        exp_cap  = '0;
        exp_rd_t = 1'b0;
        exp_wr_t = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                exp_cap  = '0;
                exp_rd_t = 1'b0;
                exp_wr_t = 1'b0;
            end else begin
                chk("rd_done_lvl", {31'b0, master_read_done}, {31'b0, exp_rd_t});
                chk("wr_done_lvl", {31'b0, master_write_done}, {31'b0, exp_wr_t});
                chk("captured", captured_readdata, exp_cap);
                chk("no_overlap", {31'b0, master_read & master_write}, 32'd0);
                if ((master_read || master_write) && !master_waitrequest) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_xfer", {31'b0, master_read}, {31'b0, ~master_read});
                    end else begin
                        x = sb.pop_front();
                        chk("xfer_kind", {31'b0, master_read}, {31'b0, x.is_rd});
                        if (master_read) begin
                            exp_rd_t = ~exp_rd_t;
                            exp_cap  = x.data;
                        end else begin
                            exp_wr_t = ~exp_wr_t;
                        end
                    end
                end
            end
        end
    end

    // One transfer with `stall` waitrequest cycles; readdata is only valid on
    // the completion cycle so a wrong capture edge is visible.
    task automatic xfer(input bit is_rd, input int stall, input logic [31:0] data);
        int n;
        sb.push_back('{is_rd: is_rd, data: data});
        slave_read_request  = is_rd;
        slave_write_request = !is_rd;
        master_waitrequest  = (stall > 0);
        master_readdata     = (stall > 0) ? ~data : data;
        tick();
        slave_read_request  = 1'b0;
        slave_write_request = 1'b0;
        n = 0;
        for (int k = 0; k < 64; k++) begin
            if (!(is_rd ? master_read : master_write)) break;
            master_waitrequest = (n < stall);
            master_readdata    = (n < stall) ? ~data : data;
            n++;
            tick();
        end
        chk(is_rd ? "rd_strobe_len" : "wr_strobe_len", n, stall + 1);
        master_waitrequest = 1'b0;
        tick();
    endtask

    initial begin
        bit    rd;
        int    st;
        logic [31:0] d;

        reset_n             = 1'b0;
        slave_read_request  = 1'b0;
        slave_write_request = 1'b0;
        master_waitrequest  = 1'b0;
        master_readdata     = '0;
        #12;
        chk("rst_read", {31'b0, master_read}, 32'd0);
        chk("rst_write", {31'b0, master_write}, 32'd0);
        chk("rst_rd_done", {31'b0, master_read_done}, 32'd0);
        chk("rst_wr_done", {31'b0, master_write_done}, 32'd0);
        chk("rst_captured", captured_readdata, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single read, no stall: strobe one cycle after the pulse, one cycle long.
        sb.push_back('{is_rd: 1'b1, data: 32'hDEADBEEF});
        master_readdata    = 32'hDEADBEEF;
        slave_read_request = 1'b1;
        tick();
        slave_read_request = 1'b0;
        chk("rd_latency", {31'b0, master_read}, 32'd1);
        tick();
        chk("rd_drop", {31'b0, master_read}, 32'd0);
        chk("rd_capture", captured_readdata, 32'hDEADBEEF);
        chk("rd_done_toggle", {31'b0, master_read_done}, 32'd1);
        tick();

        // Write with three waitrequest cycles -> four-cycle strobe.
        xfer(1'b0, 3, 32'h0);
        chk("wr_done_toggle", {31'b0, master_write_done}, 32'd1);

        // Simultaneous requests: read first, one idle cycle, then write.
        sb.push_back('{is_rd: 1'b1, data: 32'h12345678});
        sb.push_back('{is_rd: 1'b0, data: 32'h0});
        master_readdata     = 32'h12345678;
        slave_read_request  = 1'b1;
        slave_write_request = 1'b1;
        tick();
        slave_read_request  = 1'b0;
        slave_write_request = 1'b0;
        chk("sim_read_first", {30'b0, master_read, master_write}, 32'd2);
        tick();
        chk("sim_idle_gap", {30'b0, master_read, master_write}, 32'd0);
        tick();
        chk("sim_write_next", {30'b0, master_read, master_write}, 32'd1);
        tick();
        chk("sim_write_drop", {31'b0, master_write}, 32'd0);
        tick();

        // Two read pulses during a stalled write merge into one read.
        sb.push_back('{is_rd: 1'b0, data: 32'h0});
        sb.push_back('{is_rd: 1'b1, data: 32'hCAFEF00D});
        master_readdata     = 32'hCAFEF00D;
        master_waitrequest  = 1'b1;
        slave_write_request = 1'b1;
        tick();
        slave_write_request = 1'b0;
        slave_read_request  = 1'b1;
        tick();
        slave_read_request  = 1'b0;
        tick();
        slave_read_request  = 1'b1;
        tick();
        slave_read_request  = 1'b0;
        chk("merge_no_read_busy", {31'b0, master_read}, 32'd0);
        master_waitrequest  = 1'b0;
        tick();
        chk("merge_wr_drop", {30'b0, master_read, master_write}, 32'd0);
        tick();
        chk("merge_read_issued", {31'b0, master_read}, 32'd1);
        for (int k = 0; k < 6; k++) tick();
        chk("merge_sb_empty", sb.size(), 32'd0);

        // Reset while a read is held by waitrequest.
        master_waitrequest = 1'b1;
        slave_read_request = 1'b1;
        tick();
        slave_read_request = 1'b0;
        tick();
        chk("rst_mid_read_held", {31'b0, master_read}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_read", {31'b0, master_read}, 32'd0);
        chk("rst_mid_rd_done", {31'b0, master_read_done}, 32'd0);
        chk("rst_mid_wr_done", {31'b0, master_write_done}, 32'd0);
        chk("rst_mid_captured", captured_readdata, 32'd0);
        tick();
        master_waitrequest = 1'b0;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rst_no_reissue", {30'b0, master_read, master_write}, 32'd0);
        end

        // Alternating reads and writes with random stall.
        for (int i = 0; i < 5; i++) begin
            rd = (i % 2) == 0;
            st = $urandom_range(0, 3);
            d  = $urandom;
            xfer(rd, st, d);
        end
        tick();
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1);
    end

endmodule
